// File: rtl/spatz_spm_responder.sv
// SPM responder: accepts q-channel requests, drives a fixed-latency SRAM port
// and returns in-order p-channel responses through a fall-through FIFO.
// A credit counter bounds the number of outstanding requests, so a response
// never finds the FIFO full.
module spatz_spm_responder #(
  parameter int unsigned AddrWidth   = 16,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned UserWidth   = 1,
  parameter int unsigned SpmSize     = 65536,
  parameter int unsigned SramLatency = 1,
  parameter int unsigned FifoDepth   = 2,
  localparam int unsigned StrbWidth  = DataWidth / 8,
  localparam int unsigned ByteOffW   = $clog2(StrbWidth),
  localparam int unsigned WordAddrW  = AddrWidth - ByteOffW
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 q_valid_i,
  output logic                 q_ready_o,
  input  logic [AddrWidth-1:0] q_addr_i,
  input  logic                 q_write_i,
  input  logic [3:0]           q_amo_i,
  input  logic [DataWidth-1:0] q_data_i,
  input  logic [StrbWidth-1:0] q_strb_i,
  input  logic [UserWidth-1:0] q_user_i,
  output logic                 p_valid_o,
  input  logic                 p_ready_i,
  output logic [DataWidth-1:0] p_data_o,
  output logic                 p_error_o,
  output logic [UserWidth-1:0] p_user_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [WordAddrW-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [StrbWidth-1:0] sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  localparam int unsigned CntW = $clog2(FifoDepth + 1);
  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned EntW = 1 + UserWidth + DataWidth;
  localparam logic [CntW-1:0]      DepthCnt = CntW'(FifoDepth);
  localparam logic [PtrW-1:0]      LastPtr  = PtrW'(FifoDepth - 1);
  localparam logic [AddrWidth:0]   SpmLimit = (AddrWidth + 1)'(SpmSize);

  // Parameter sanity checks, evaluated at elaboration.
  if (FifoDepth < 1) begin : g_bad_depth
    $error("FifoDepth must be at least 1");
  end
  if (SramLatency < 1) begin : g_bad_latency
    $error("SramLatency must be at least 1");
  end
  if ((DataWidth < 8) || ((DataWidth & (DataWidth - 1)) != 0)) begin : g_bad_width
    $error("DataWidth must be a power of two and at least 8");
  end
  if (longint'(SpmSize) > (longint'(1) << AddrWidth)) begin : g_bad_size
    $error("SpmSize must not exceed 2**AddrWidth");
  end

  // ---------------------------------------------------------------------------
  // Request side
  // ---------------------------------------------------------------------------
  logic [CntW-1:0] outstanding_reg, outstanding_next;
  logic            q_hs, p_hs, req_error;

  // Ready depends only on the credit register, never on p_ready_i.
  assign q_ready_o = (outstanding_reg < DepthCnt);
  assign q_hs      = q_valid_i & q_ready_o;
  assign req_error = (q_amo_i != 4'd0) | ({1'b0, q_addr_i} >= SpmLimit);

  // Error requests never reach the macro; idle outputs are forced to zero.
  assign sram_req_o   = q_hs & ~req_error;
  assign sram_we_o    = sram_req_o & q_write_i;
  assign sram_addr_o  = sram_req_o ? q_addr_i[AddrWidth-1:ByteOffW] : '0;
  assign sram_wdata_o = sram_req_o ? q_data_i : '0;
  assign sram_be_o    = sram_req_o ? q_strb_i : '0;

  // ---------------------------------------------------------------------------
  // Meta pipeline, one stage per cycle of SRAM latency
  // ---------------------------------------------------------------------------
  logic                 pipe_valid_reg [SramLatency];
  logic                 pipe_write_reg [SramLatency];
  logic                 pipe_error_reg [SramLatency];
  logic [UserWidth-1:0] pipe_user_reg  [SramLatency];

  genvar gi;
  generate
    for (gi = 0; gi < SramLatency; gi++) begin : g_stage
      logic                 in_valid, in_write, in_error;
      logic [UserWidth-1:0] in_user;

      if (gi == 0) begin : g_head
        assign in_valid = q_hs;
        assign in_write = q_write_i;
        assign in_error = req_error;
        assign in_user  = q_user_i;
      end else begin : g_body
        assign in_valid = pipe_valid_reg[gi-1];
        assign in_write = pipe_write_reg[gi-1];
        assign in_error = pipe_error_reg[gi-1];
        assign in_user  = pipe_user_reg[gi-1];
      end

      // Advance request metadata in lockstep with the SRAM access.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          pipe_valid_reg[gi] <= 1'b0;
          pipe_write_reg[gi] <= 1'b0;
          pipe_error_reg[gi] <= 1'b0;
          pipe_user_reg[gi]  <= '0;
        end else begin
          pipe_valid_reg[gi] <= in_valid;
          pipe_write_reg[gi] <= in_write;
          pipe_error_reg[gi] <= in_error;
          pipe_user_reg[gi]  <= in_user;
        end
      end
    end
  endgenerate

  logic            push;
  logic            push_read_ok;
  logic [EntW-1:0] push_entry;

  assign push         = pipe_valid_reg[SramLatency-1];
  assign push_read_ok = ~pipe_write_reg[SramLatency-1] & ~pipe_error_reg[SramLatency-1];
  assign push_entry   = {pipe_error_reg[SramLatency-1], pipe_user_reg[SramLatency-1],
                         push_read_ok ? sram_rdata_i : {DataWidth{1'b0}}};

  // ---------------------------------------------------------------------------
  // Fall-through response FIFO
  // ---------------------------------------------------------------------------
  logic [EntW-1:0] fifo_mem [FifoDepth];
  logic [PtrW-1:0] rptr_reg, rptr_next, wptr_reg, wptr_next;
  logic [CntW-1:0] count_reg, count_next;
  logic            fifo_empty, fifo_write, fifo_read;
  logic [EntW-1:0] head_entry;

  assign fifo_empty = (count_reg == '0);
  assign p_valid_o  = ~fifo_empty | push;
  assign p_hs       = p_valid_o & p_ready_i;
  // A push into an empty FIFO that is consumed at once bypasses storage.
  assign fifo_write = push & ~(fifo_empty & p_ready_i);
  assign fifo_read  = p_hs & ~fifo_empty;
  assign head_entry = fifo_empty ? push_entry : fifo_mem[rptr_reg];
  assign {p_error_o, p_user_o, p_data_o} = p_valid_o ? head_entry : '0;

  // Pointer, occupancy and credit bookkeeping.
  always_comb begin
    rptr_next        = rptr_reg;
    wptr_next        = wptr_reg;
    count_next       = count_reg;
    outstanding_next = outstanding_reg;
    if (fifo_write) begin
      wptr_next = (wptr_reg == LastPtr) ? '0 : wptr_reg + PtrW'(1);
    end
    if (fifo_read) begin
      rptr_next = (rptr_reg == LastPtr) ? '0 : rptr_reg + PtrW'(1);
    end
    case ({fifo_write, fifo_read})
      2'b10:   count_next = count_reg + CntW'(1);
      2'b01:   count_next = count_reg - CntW'(1);
      default: count_next = count_reg;
    endcase
    case ({q_hs, p_hs})
      2'b10:   outstanding_next = outstanding_reg + CntW'(1);
      2'b01:   outstanding_next = outstanding_reg - CntW'(1);
      default: outstanding_next = outstanding_reg;
    endcase
  end

  // State registers; reset discards everything in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_reg        <= '0;
      wptr_reg        <= '0;
      count_reg       <= '0;
      outstanding_reg <= '0;
    end else begin
      rptr_reg        <= rptr_next;
      wptr_reg        <= wptr_next;
      count_reg       <= count_next;
      outstanding_reg <= outstanding_next;
    end
  end

  // FIFO storage; contents are meaningless until counted in by count_reg.
  always_ff @(posedge clk_i) begin
    if (fifo_write) begin
      fifo_mem[wptr_reg] <= push_entry;
    end
  end

  // Credits guarantee a response never arrives while the FIFO is full.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(push && (count_reg == DepthCnt)));
    end
  end

endmodule

// File: tb/tb_spatz_spm_responder.sv
// Directed bench for spatz_spm_responder with a 1-cycle SRAM model.
module tb_spatz_spm_responder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        q_valid_i, q_ready_o, q_write_i;
  logic [15:0] q_addr_i;
  logic [3:0]  q_amo_i;
  logic [31:0] q_data_i;
  logic [3:0]  q_strb_i;
  logic [0:0]  q_user_i;
  logic        p_valid_o, p_ready_i, p_error_o;
  logic [31:0] p_data_o;
  logic [0:0]  p_user_o;
  logic        sram_req_o, sram_we_o;
  logic [13:0] sram_addr_o;
  logic [31:0] sram_wdata_o, sram_rdata_i;
  logic [3:0]  sram_be_o;

  int checks = 0;
  int errors = 0;

  spatz_spm_responder #(
    .AddrWidth(16), .DataWidth(32), .UserWidth(1),
    .SpmSize(32768), .SramLatency(1), .FifoDepth(2)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .q_valid_i(q_valid_i), .q_ready_o(q_ready_o), .q_addr_i(q_addr_i),
    .q_write_i(q_write_i), .q_amo_i(q_amo_i), .q_data_i(q_data_i),
    .q_strb_i(q_strb_i), .q_user_i(q_user_i),
    .p_valid_o(p_valid_o), .p_ready_i(p_ready_i), .p_data_o(p_data_o),
    .p_error_o(p_error_o), .p_user_o(p_user_o),
    .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o), .sram_rdata_i(sram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // SRAM model: never-written words read back as {16'hC0DE, word address}.
  logic [31:0] sram_mem [16384];
  bit          sram_written [16384];
  always @(posedge clk_i) begin
    if (sram_req_o) begin
      if (sram_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (sram_be_o[b]) sram_mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
        end
        sram_written[sram_addr_o] <= 1'b1;
      end else begin
        sram_rdata_i <= sram_written[sram_addr_o] ? sram_mem[sram_addr_o]
                                                  : {16'hC0DE, 2'b00, sram_addr_o};
      end
    end
  end

  // One line per handshake on either channel.
  always @(negedge clk_i) begin
    if (rst_ni && q_valid_i && q_ready_o)
      $display("%0t Q addr=%h we=%b amo=%h data=%h strb=%b user=%b", $time,
               q_addr_i, q_write_i, q_amo_i, q_data_i, q_strb_i, q_user_i);
    if (rst_ni && p_valid_o && p_ready_i)
      $display("%0t P data=%h err=%b user=%b", $time, p_data_o, p_error_o, p_user_o);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, then settle to mid-cycle.
  task automatic drive(input logic v, input logic w, input logic [15:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic [3:0] amo, input logic u, input logic pr);
    @(posedge clk_i);
    #1;
    q_valid_i = v; q_write_i = w; q_addr_i = a; q_data_i = d;
    q_strb_i = s; q_amo_i = amo; q_user_i = u; p_ready_i = pr;
    #3;
  endtask

  initial begin
    rst_ni = 1'b0;
    q_valid_i = 1'b0; q_write_i = 1'b0; q_addr_i = '0; q_data_i = '0;
    q_strb_i = '0; q_amo_i = '0; q_user_i = '0; p_ready_i = 1'b0;

    // Reset state
    repeat (3) @(posedge clk_i);
    #4;
    check("rst_p_valid", p_valid_o, 0);
    check("rst_q_ready", q_ready_o, 1);
    check("rst_sram_req", sram_req_o, 0);
    check("rst_p_data", p_data_o, 0);
    check("rst_sram_addr", sram_addr_o, 0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Write 0xDEADBEEF @0x10, then read it back
    drive(1, 1, 16'h0010, 32'hDEADBEEF, 4'hF, 4'h0, 0, 1);
    check("wr_sram_req", sram_req_o, 1);
    check("wr_sram_we", sram_we_o, 1);
    check("wr_sram_addr", sram_addr_o, 32'h4);
    check("wr_sram_wdata", sram_wdata_o, 32'hDEADBEEF);
    check("wr_sram_be", sram_be_o, 32'hF);
    check("wr_p_valid_early", p_valid_o, 0);
    drive(0, 0, 16'h0, 32'h0, 4'h0, 4'h0, 0, 1);
    check("wr_resp_valid", p_valid_o, 1);
    check("wr_resp_data", p_data_o, 0);
    check("wr_resp_err", p_error_o, 0);
    drive(1, 0, 16'h0010, 32'h0, 4'hF, 4'h0, 1, 1);
    check("rd_sram_req", sram_req_o, 1);
    check("rd_sram_we", sram_we_o, 0);
    check("rd_p_valid_early", p_valid_o, 0);
    drive(0, 0, 16'h0, 32'h0, 4'h0, 4'h0, 0, 1);
    check("rd_p_valid", p_valid_o, 1);
    check("rd_p_data", p_data_o, 32'hDEADBEEF);
    check("rd_p_err", p_error_o, 0);
    check("rd_p_user", p_user_o, 1);

    // Streaming: 8 back-to-back reads, one response per cycle
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 16'(16'h0100 + 4 * i), 32'h0, 4'hF, 4'h0, 1'(i), 1);
      check($sformatf("stream_q_ready_%0d", i), q_ready_o, 1);
      if (i > 0) begin
        check($sformatf("stream_p_valid_%0d", i - 1), p_valid_o, 1);
        check($sformatf("stream_p_data_%0d", i - 1), p_data_o, 32'hC0DE0040 + 32'(i - 1));
        check($sformatf("stream_p_user_%0d", i - 1), p_user_o, 32'((i - 1) % 2));
      end
    end
    drive(0, 0, 16'h0, 32'h0, 4'h0, 4'h0, 0, 1);
    check("stream_p_valid_7", p_valid_o, 1);
    check("stream_p_data_7", p_data_o, 32'hC0DE0047);
    drive(0, 0, 16'h0, 32'h0, 4'h0, 4'h0, 0, 1);
    check("stream_idle", p_valid_o, 0);

    // Backpressure: 5 reads with p_ready low, only two accepted
    drive(1, 0, 16'h0200, 32'h0, 4'hF, 4'h0, 0, 0);
    check("bp_q_ready_a0", q_ready_o, 1);
    drive(1, 0, 16'h0204, 32'h0, 4'hF, 4'h0, 0, 0);
    check("bp_q_ready_a1", q_ready_o, 1);
    check("bp_p_data_c1", p_data_o, 32'hC0DE0080);
    drive(1, 0, 16'h0208, 32'h0, 4'hF, 4'h0, 0, 0);
    check("bp_q_ready_full", q_ready_o, 0);
    check("bp_sram_req_full", sram_req_o, 0);
    check("bp_p_data_c2", p_data_o, 32'hC0DE0080);
    drive(1, 0, 16'h0208, 32'h0, 4'hF, 4'h0, 0, 0);
    check("bp_q_ready_hold", q_ready_o, 0);
    check("bp_p_valid_hold", p_valid_o, 1);
    check("bp_p_data_hold", p_data_o, 32'hC0DE0080);
    drive(1, 0, 16'h0208, 32'h0, 4'hF, 4'h0, 0, 1);
    check("bp_q_ready_c4", q_ready_o, 0);
    check("bp_p_data_c4", p_data_o, 32'hC0DE0080);
    drive(1, 0, 16'h0208, 32'h0, 4'hF, 4'h0, 0, 1);
    check("bp_q_ready_c5", q_ready_o, 1);
    check("bp_sram_req_c5", sram_req_o, 1);
    check("bp_p_data_c5", p_data_o, 32'hC0DE0081);
    drive(1, 0, 16'h020C, 32'h0, 4'hF, 4'h0, 0, 1);
    check("bp_q_ready_c6", q_ready_o, 1);
    check("bp_p_data_c6", p_data_o, 32'hC0DE0082);
    drive(1, 0, 16'h0210, 32'h0, 4'hF, 4'h0, 0, 1);
    check("bp_q_ready_c7", q_ready_o, 1);
    check("bp_p_data_c7", p_data_o, 32'hC0DE0083);
    drive(0, 0, 16'h0, 32'h0, 4'h0, 4'h0, 0, 1);
    check("bp_p_valid_c8", p_valid_o, 1);
    check("bp_p_data_c8", p_data_o, 32'hC0DE0084);
    drive(0, 0, 16'h0, 32'h0, 4'h0, 4'h0, 0, 1);
    check("bp_drained", p_valid_o, 0);

    // Errors: AMO and out-of-range address keep their slot in order
    drive(1, 0, 16'h0010, 32'h0, 4'hF, 4'h2, 1, 1);
    check("err_amo_sram_req", sram_req_o, 0);
    check("err_amo_q_ready", q_ready_o, 1);
    drive(1, 0, 16'h8000, 32'h0, 4'hF, 4'h0, 0, 1);
    check("err_range_sram_req", sram_req_o, 0);
    check("err_amo_p_valid", p_valid_o, 1);
    check("err_amo_p_error", p_error_o, 1);
    check("err_amo_p_data", p_data_o, 0);
    check("err_amo_p_user", p_user_o, 1);
    drive(1, 0, 16'h0010, 32'h0, 4'hF, 4'h0, 1, 1);
    check("err_ok_sram_req", sram_req_o, 1);
    check("err_range_p_error", p_error_o, 1);
    check("err_range_p_data", p_data_o, 0);
    check("err_range_p_user", p_user_o, 0);
    drive(0, 0, 16'h0, 32'h0, 4'h0, 4'h0, 0, 1);
    check("err_ok_p_error", p_error_o, 0);
    check("err_ok_p_data", p_data_o, 32'hDEADBEEF);
    check("err_ok_p_user", p_user_o, 1);

    // Partial write over 0xFFFFFFFF
    drive(1, 1, 16'h0020, 32'hFFFFFFFF, 4'hF, 4'h0, 0, 1);
    check("pw_full_sram_req", sram_req_o, 1);
    drive(1, 1, 16'h0020, 32'h12345678, 4'b0011, 4'h0, 0, 1);
    check("pw_sram_be", sram_be_o, 32'h3);
    check("pw_sram_wdata", sram_wdata_o, 32'h12345678);
    check("pw_resp0_data", p_data_o, 0);
    drive(1, 0, 16'h0020, 32'h0, 4'hF, 4'h0, 0, 1);
    check("pw_resp1_valid", p_valid_o, 1);
    drive(0, 0, 16'h0, 32'h0, 4'h0, 4'h0, 0, 1);
    check("pw_readback", p_data_o, 32'hFFFF5678);

    // Reset with two outstanding requests
    drive(1, 0, 16'h0010, 32'h0, 4'hF, 4'h0, 0, 0);
    drive(1, 0, 16'h0014, 32'h0, 4'hF, 4'h0, 0, 0);
    check("rr_q_ready_second", q_ready_o, 1);
    drive(0, 0, 16'h0, 32'h0, 4'h0, 4'h0, 0, 0);
    check("rr_q_ready_full", q_ready_o, 0);
    check("rr_p_valid_full", p_valid_o, 1);
    #1 rst_ni = 1'b0;
    #1;
    check("rr_p_valid_async", p_valid_o, 0);
    check("rr_q_ready_async", q_ready_o, 1);
    @(posedge clk_i);
    #4;
    check("rr_p_valid_next", p_valid_o, 0);
    check("rr_q_ready_next", q_ready_o, 1);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    drive(0, 0, 16'h0, 32'h0, 4'h0, 4'h0, 0, 1);
    check("rr_no_stale_0", p_valid_o, 0);
    drive(0, 0, 16'h0, 32'h0, 4'h0, 4'h0, 0, 1);
    check("rr_no_stale_1", p_valid_o, 0);
    drive(1, 0, 16'h0010, 32'h0, 4'hF, 4'h0, 1, 1);
    check("rr_after_q_ready", q_ready_o, 1);
    drive(0, 0, 16'h0, 32'h0, 4'h0, 4'h0, 0, 1);
    check("rr_after_p_valid", p_valid_o, 1);
    check("rr_after_p_data", p_data_o, 32'hDEADBEEF);
    drive(0, 0, 16'h0, 32'h0, 4'h0, 4'h0, 0, 1);
    check("rr_after_idle", p_valid_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
